// File: rtl/lab3_request_debouncer_pkg.sv
// ----------------------------------------------------------------------------
// lab3_pkg
// Shared types and constants for the 4-line request debouncer.
//   line_state_e             : per-line debounce state
//   DEBOUNCE_CYCLES_DEFAULT  : default number of consecutive stable samples
// ----------------------------------------------------------------------------
package lab3_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
   localparam int unsigned NUM_LINES               = 4;

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      CHK_HIGH = 2'd1,
      HIGH     = 2'd2,
      CHK_LOW  = 2'd3
   } line_state_e;

endpackage

// File: rtl/lab3_request_debouncer_debounce_line.sv
// ----------------------------------------------------------------------------
// debounce_line
// Single-bit debouncer: state machine, stability counter and rise pulse.
// Ports:
//   clk_i   : system clock, rising edge
//   rst_i   : synchronous active-high reset
//   s_i     : sampled input line
//   d_o     : debounced level (registered)
//   rise_o  : one-cycle pulse on debounced 0->1 (registered)
//   chk_o   : high while the line is in a checking state (registered)
// ----------------------------------------------------------------------------
module debounce_line
   import lab3_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic s_i,
   output logic d_o,
   output logic rise_o,
   output logic chk_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   // The transition into CHK_* counts as the first stable sample, so the
   // counter only has to reach DEBOUNCE_CYCLES-2 before the final edge.
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 2);

   line_state_e     state_q;
   logic [CntW-1:0] cnt_q;
   logic            d_q;
   logic            rise_q;
   logic            chk_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= LOW;
         cnt_q   <= '0;
         d_q     <= 1'b0;
         rise_q  <= 1'b0;
         chk_q   <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         unique case (state_q)
            LOW: begin
               if (s_i) begin
                  state_q <= CHK_HIGH;
                  cnt_q   <= '0;
                  chk_q   <= 1'b1;
               end
            end
            CHK_HIGH: begin
               if (!s_i) begin
                  // bounce rejected
                  state_q <= LOW;
                  cnt_q   <= '0;
                  chk_q   <= 1'b0;
               end else if (cnt_q == CntLast) begin
                  state_q <= HIGH;
                  cnt_q   <= '0;
                  d_q     <= 1'b1;
                  rise_q  <= 1'b1;
                  chk_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            HIGH: begin
               if (!s_i) begin
                  state_q <= CHK_LOW;
                  cnt_q   <= '0;
                  chk_q   <= 1'b1;
               end
            end
            CHK_LOW: begin
               if (s_i) begin
                  state_q <= HIGH;
                  cnt_q   <= '0;
                  chk_q   <= 1'b0;
               end else if (cnt_q == CntLast) begin
                  state_q <= LOW;
                  cnt_q   <= '0;
                  d_q     <= 1'b0;
                  chk_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: begin
               state_q <= LOW;
               cnt_q   <= '0;
               d_q     <= 1'b0;
               chk_q   <= 1'b0;
            end
         endcase
      end
   end

   assign d_o    = d_q;
   assign rise_o = rise_q;
   assign chk_o  = chk_q;

endmodule

// File: rtl/lab3_request_debouncer.sv
// ----------------------------------------------------------------------------
// lab3_request_debouncer
// Debounces four raw request lines feeding a priority encoder.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   btn_in  : [3:0] raw bouncy request lines
//   D       : [3:0] debounced request vector
//   rise    : [3:0] one-cycle pulse per line on debounced 0->1
//   stable  : high when no line is mid-check
// Build option:
//   DEBOUNCE_SYNC2_EN : insert a two-flop synchronizer ahead of the lines
//                       (adds two cycles of latency)
// ----------------------------------------------------------------------------
module lab3_request_debouncer
   import lab3_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn_in,
   output logic [3:0] D,
   output logic [3:0] rise,
   output logic       stable
);

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_param_check
      $error("DEBOUNCE_CYCLES out of range 2..255");
   end

   logic [3:0] samp;
   logic [3:0] chk;

`ifdef DEBOUNCE_SYNC2_EN
   logic [3:0] sync1_q;
   logic [3:0] sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
      end
   end

   assign samp = sync2_q;
`else
   assign samp = btn_in;
`endif

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      debounce_line #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_line (
         .clk_i  (clk),
         .rst_i  (rst),
         .s_i    (samp[g]),
         .d_o    (D[g]),
         .rise_o (rise[g]),
         .chk_o  (chk[g])
      );
   end

   assign stable = ~|chk;

endmodule

// File: tb/tb_lab3_request_debouncer.sv
module tb_lab3_request_debouncer;

   localparam int N = 4;
`ifdef DEBOUNCE_SYNC2_EN
   localparam int LAT = N + 2;
`else
   localparam int LAT = N;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_in = 4'b0000;
   logic [3:0] D;
   logic [3:0] rise;
   logic       stable;

   int n_checks = 0;
   int n_fail   = 0;

   lab3_request_debouncer #(
      .DEBOUNCE_CYCLES(N)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_in),
      .D      (D),
      .rise   (rise),
      .stable (stable)
   );

   always #5 clk = ~clk;

   // Reference model: per line, count consecutive samples differing from the
   // debounced level; flip once the count reaches N.
   logic [3:0] m_d;
   logic [3:0] m_rise;
   int         m_run[4];
   logic [3:0] m_s1, m_s2;
   logic [3:0] m_samp;
   logic       m_stable;

`ifdef DEBOUNCE_SYNC2_EN
   assign m_samp = m_s2;
`else
   assign m_samp = btn_in;
`endif

   always_comb begin
      m_stable = 1'b1;
      for (int i = 0; i < 4; i++) if (m_run[i] != 0) m_stable = 1'b0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_d    <= '0;
         m_rise <= '0;
         m_s1   <= '0;
         m_s2   <= '0;
         for (int i = 0; i < 4; i++) m_run[i] <= 0;
      end else begin
         m_s1 <= btn_in;
         m_s2 <= m_s1;
         for (int i = 0; i < 4; i++) begin
            if (m_samp[i] != m_d[i]) begin
               if (m_run[i] + 1 == N) begin
                  m_d[i]    <= m_samp[i];
                  m_rise[i] <= m_samp[i];
                  m_run[i]  <= 0;
               end else begin
                  m_run[i]  <= m_run[i] + 1;
                  m_rise[i] <= 1'b0;
               end
            end else begin
               m_run[i]  <= 0;
               m_rise[i] <= 1'b0;
            end
         end
      end
   end

   // Advance one clock; inputs change and outputs are sampled at the negedge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      btn_in = 4'b0000;
      rst    = 1'b1;
      step();
      rst    = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst    = 1'b1;
      btn_in = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) rst = 1'b0;
         if (k < 2) step();
         n_checks++;
         if ({D, rise, stable} !== 9'b0000_0000_1) begin
            n_fail++;
            $display("FAIL reset[%0d]: D=%b rise=%b stable=%b, want D=0000 rise=0000 stable=1",
                     k, D, rise, stable);
         end
      end
      do_reset();
   endtask

   task automatic test_single_line();
      logic [3:0] exp_d, exp_r;
      logic       exp_s;
      do_reset();
      btn_in = 4'b0100;
      for (int k = 1; k <= LAT + 2; k++) begin
         step();
         exp_d = (k >= LAT) ? 4'b0100 : 4'b0000;
         exp_r = (k == LAT) ? 4'b0100 : 4'b0000;
         exp_s = !(k >= LAT - N + 1 && k < LAT);
         n_checks++;
         if (D !== exp_d || rise !== exp_r || stable !== exp_s) begin
            n_fail++;
            $display("FAIL single_line[%0d]: D=%b rise=%b stable=%b, want %b %b %b",
                     k, D, rise, stable, exp_d, exp_r, exp_s);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      btn_in = 4'b0010;
      for (int k = 1; k <= LAT + 4; k++) begin
         if (k == 4) btn_in = 4'b0000;
         step();
         n_checks++;
         if (D !== 4'b0000 || rise !== 4'b0000) begin
            n_fail++;
            $display("FAIL glitch[%0d]: D=%b rise=%b, want 0000 0000", k, D, rise);
         end
      end
      n_checks++;
      if (stable !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_stable: stable=%b, want 1", stable);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_d, exp_r;
      do_reset();
      btn_in = 4'b1001;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         exp_d = (k >= LAT) ? 4'b1001 : 4'b0000;
         exp_r = (k == LAT) ? 4'b1001 : 4'b0000;
         n_checks++;
         if (D !== exp_d || rise !== exp_r) begin
            n_fail++;
            $display("FAIL simul_rise[%0d]: D=%b rise=%b, want %b %b", k, D, rise, exp_d, exp_r);
         end
      end
      btn_in = 4'b0000;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         exp_d = (k >= LAT) ? 4'b0000 : 4'b1001;
         n_checks++;
         if (D !== exp_d || rise !== 4'b0000) begin
            n_fail++;
            $display("FAIL simul_fall[%0d]: D=%b rise=%b, want %b 0000", k, D, rise, exp_d);
         end
      end
   endtask

   task automatic test_reset_mid_check();
      logic [3:0] exp_d;
      do_reset();
      btn_in = 4'b1000;
      step();
      step();
      rst = 1'b1;
      step();
      n_checks++;
      if (D !== 4'b0000 || rise !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_reset: D=%b rise=%b, want 0000 0000", D, rise);
      end
      rst = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         exp_d = (k >= LAT) ? 4'b1000 : 4'b0000;
         n_checks++;
         if (D !== exp_d) begin
            n_fail++;
            $display("FAIL mid_reset_release[%0d]: D=%b, want %b", k, D, exp_d);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 500; k++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(5) == 0) btn_in[i] = ~btn_in[i];
         rst = ($urandom_range(79) == 0);
         step();
         n_checks++;
         if (D !== m_d || rise !== m_rise || stable !== m_stable) begin
            n_fail++;
            $display("FAIL random[%0d]: D=%b rise=%b stable=%b, want %b %b %b",
                     k, D, rise, stable, m_d, m_rise, m_stable);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_line();
      test_glitch();
      test_simultaneous();
      test_reset_mid_check();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
